pipeline_wb_regfile: RTL

Write-back stage and architectural register file of the 5-stage pipelined CPU; the consumer end of the MEM/WB pipeline register. It unpacks the packed MEM/WB word, selects the write-back value, commits it to a 32×32 register file on the clock edge, and serves the two ID-stage read ports. Same-cycle write-through bypass means ID never reads a stale value being retired. It also exports the write-back value for EX forwarding and a retired-write counter.

---
 rtl/cpu_pipe_pkg.sv | 34 +++
 rtl/regfile_core.sv | 30 +++
 rtl/pipeline_wb_regfile.sv | 51 +++++
 3 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared MEM/WB pipeline definitions: packed word layout, field bounds and
// write-back source encodings.
package cpu_pipe_pkg;

  localparam int MEMWB_W  = 69;
  localparam int ADDRC_HI = 68;
  localparam int ADDRC_LO = 64;
  localparam int RDATA_HI = 63;
  localparam int RDATA_LO = 32;
  localparam int ALU_HI   = 31;
  localparam int ALU_LO   = 0;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;

  // Field order mirrors the bit bounds above, MSB first.
  typedef struct packed {
    logic [ADDRC_HI-ADDRC_LO:0] addr_c;
    logic [RDATA_HI-RDATA_LO:0] read_data;
    logic [ALU_HI-ALU_LO:0]     alu_out;
  } memwb_t;

  // Only a load selects ReadData; link and the reserved code both take ALUOut.
  function automatic logic [31:0] wb_select(input logic [1:0]  sel,
                                            input logic [31:0] alu_out,
                                            input logic [31:0] read_data);
    logic [31:0] res;
    res = alu_out;
    if (sel == WB_SEL_MEM) res = read_data;
    return res;
  endfunction

endpackage

// File: rtl/regfile_core.sv
// 31-entry architectural storage with async clear, one write port and two raw
// read ports; register 0 is not stored and always reads as zero.
module regfile_core
  import cpu_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);

  logic [31:0] mem [1:31];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/pipeline_wb_regfile.sv
// Write-back stage: unpacks MEM/WB, selects the write-back value, commits it to
// the register file and bypasses it onto the ID read ports in the same cycle.
module pipeline_wb_regfile
  import cpu_pipe_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [MEMWB_W-1:0] MEMWB_data,
  input  logic               MEMWB_RegWr,
  input  logic [1:0]         MEMWB_MemToReg,
  input  logic [4:0]         rs_addr,
  input  logic [4:0]         rt_addr,
  output logic [31:0]        rs_data,
  output logic [31:0]        rt_data,
  output logic               wb_en,
  output logic [4:0]         wb_addr,
  output logic [31:0]        wb_data,
  output logic [31:0]        wb_count
);

  memwb_t      memwb;
  logic [31:0] raw_a;
  logic [31:0] raw_b;

  assign memwb   = memwb_t'(MEMWB_data);
  assign wb_addr = memwb.addr_c;
  assign wb_data = wb_select(MEMWB_MemToReg, memwb.alu_out, memwb.read_data);
  assign wb_en   = MEMWB_RegWr && (memwb.addr_c != '0);

  regfile_core u_core (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs_addr),
    .raddr_b (rt_addr),
    .rdata_a (raw_a),
    .rdata_b (raw_b)
  );

  // wb_en is never set for register 0, so the bypass cannot leak a value there.
  assign rs_data = (wb_en && (rs_addr == wb_addr)) ? wb_data : raw_a;
  assign rt_data = (wb_en && (rt_addr == wb_addr)) ? wb_data : raw_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     wb_count <= '0;
    else if (wb_en) wb_count <= wb_count + 32'd1;
  end

endmodule
